ssd_digit_editor: RTL and testbench

SSD_DIGIT_EDITOR -- requirements
Module: ssd_digit_editor

---
 rtl/ssd_digit_editor.sv | 118 +++++++++++
 tb/tb_ssd_digit_editor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ssd_digit_editor.sv
// ssd_digit_editor: debounced button editor for a multi-digit segment display word.
// Optional blink of the last-edited digit is enabled by defining SSD_BLINK_EN.
module ssd_digit_editor #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W = 8,
    parameter int DEB_W = 25,
    parameter int BLINK_W = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W-1:0]            dips,
    input  logic [NUM_DIGITS-1:0]       btn_load,
    input  logic                        btn_shift,
    input  logic                        btn_clear,
    output logic [NUM_DIGITS*SEG_W-1:0] value,
    output logic                        value_upd,
    output logic [NUM_DIGITS-1:0]       blank_mask
);
    localparam int NB = NUM_DIGITS + 2;
    localparam int VW = NUM_DIGITS * SEG_W;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SEG_W < 1 || DEB_W < 1 || BLINK_W < 1)
        $error("ssd_digit_editor: parameter out of range");

    logic [NB-1:0]    syncA, syncB, accState, relPulse;
    logic [DEB_W-1:0] lockCnt [NB];
    logic [NUM_DIGITS-1:0] relLoad;
    logic             relShift, relClear;
    logic [VW-1:0]    nextValue;

    // Button bit order is {clear, shift, load[NUM_DIGITS-1:0]} throughout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= {btn_clear, btn_shift, btn_load};
            syncB <= syncA;
        end
    end

    // Debouncers: accept a change only when idle, then lock out for a full counter wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accState <= '0;
            for (int i = 0; i < NB; i++) lockCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (lockCnt[i] != '0) begin
                    lockCnt[i] <= lockCnt[i] + 1'b1;
                end else if (syncB[i] != accState[i]) begin
                    accState[i] <= syncB[i];
                    lockCnt[i] <= DEB_W'(1);
                end
            end
        end
    end

    // A commit is the cycle in which a debouncer accepts a release.
    always_comb begin
        relPulse = '0;
        for (int i = 0; i < NB; i++) relPulse[i] = accState[i] && !syncB[i] && lockCnt[i] == '0;
    end

    assign relLoad  = relPulse[NUM_DIGITS-1:0];
    assign relShift = relPulse[NUM_DIGITS];
    assign relClear = relPulse[NUM_DIGITS+1];

    // Later assignments override earlier ones, giving clear > shift > loads.
    always_comb begin
        nextValue = value;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (relLoad[k]) nextValue[k*SEG_W +: SEG_W] = dips;
        if (relShift) nextValue = (value << SEG_W) | VW'(dips);
        if (relClear) nextValue = '0;
    end

    // Display word register; the update pulse marks every commit, even a no-op write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= '0;
            value_upd <= 1'b0;
        end else begin
            value     <= nextValue;
            value_upd <= |relPulse;
        end
    end

`ifdef SSD_BLINK_EN
    logic [NUM_DIGITS-1:0] editMask, topLoad;
    logic [BLINK_W-1:0]    blinkCnt;
    logic                  blinkPhase;

    // One-hot of the highest-index digit loaded this cycle.
    always_comb begin
        topLoad = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (relLoad[k]) topLoad = NUM_DIGITS'(1) << k;
    end

    // Track the last-edited digit and run the free blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            editMask   <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else begin
            blinkCnt   <= blinkCnt + 1'b1;
            blinkPhase <= (&blinkCnt) ? ~blinkPhase : blinkPhase;
            editMask   <= relClear ? '0 : relShift ? NUM_DIGITS'(1) : (|relLoad) ? topLoad : editMask;
        end
    end

    assign blank_mask = blinkPhase ? editMask : '0;
`else
    assign blank_mask = '0;
`endif
endmodule

// File: tb/tb_ssd_digit_editor.sv
// tb_ssd_digit_editor: scoreboard bench for ssd_digit_editor (4 digits, 8-bit segments, short debounce/blink).
module tb_ssd_digit_editor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dips = '0;
    logic [3:0]  btn_load = '0;
    logic        btn_shift = 1'b0;
    logic        btn_clear = 1'b0;
    logic [31:0] value;
    logic        value_upd;
    logic [3:0]  blank_mask;

    int checks = 0;
    int failures = 0;
    logic [31:0] sbQ [$];

    ssd_digit_editor #(.NUM_DIGITS(4), .SEG_W(8), .DEB_W(4), .BLINK_W(3)) dut (
        .clk(clk), .rst(rst), .dips(dips), .btn_load(btn_load), .btn_shift(btn_shift),
        .btn_clear(btn_clear), .value(value), .value_upd(value_upd), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bits: {clear, shift, load[3:0]}; expected word is queued at release
    task automatic pressRel(input logic [5:0] mask, input logic [7:0] d, input logic [31:0] expv);
        dips = d;
        {btn_clear, btn_shift, btn_load} = mask;
        cyc(24);
        {btn_clear, btn_shift, btn_load} = '0;
        sbQ.push_back(expv);
        cyc(24);
    endtask

    // Every update pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && value_upd) begin
            if (sbQ.size() == 0) check("upd_unexpected", value_upd, 0);
            else check("value_commit", value, sbQ.pop_front());
        end
    end

    initial begin
        int lat;
        logic ok;
        logic [3:0] bm [40];
        cyc(3);
        check("rst_value", value, 0);
        check("rst_upd", value_upd, 0);
        check("rst_blank", blank_mask, 0);
        check("rst_acc", dut.accState, 0);
        rst = 1'b0;
        cyc(2);
        dips = 8'hA5;
        btn_load[2] = 1'b1;
        cyc(24);
        check("press_no_commit", value, 0);
        btn_load[2] = 1'b0;
        sbQ.push_back(32'h00A50000);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (value_upd && lat == 0) lat = i;
        end
        check("release_latency", lat, 3);
        cyc(14);
        dips = 8'h3C;
        btn_load[0] = 1'b1; cyc(3);
        btn_load[0] = 1'b0; cyc(3);
        btn_load[0] = 1'b1; cyc(3);
        btn_load[0] = 1'b0; cyc(3);
        btn_load[0] = 1'b1; cyc(1);
        btn_load[0] = 1'b0;
        sbQ.push_back(32'h00A5003C);
        cyc(30);
        check("bounce_value", value, 32'h00A5003C);
        pressRel(6'h0F, 8'h77, 32'h77777777);
        pressRel(6'h08, 8'h11, 32'h11777777);
        pressRel(6'h04, 8'h22, 32'h11227777);
        pressRel(6'h02, 8'h33, 32'h11223377);
        pressRel(6'h01, 8'h44, 32'h11223344);
        check("setup_value", value, 32'h11223344);
        pressRel(6'h10, 8'h55, 32'h22334455);
        check("shift_value", value, 32'h22334455);
        pressRel(6'h01, 8'h55, 32'h22334455);
        pressRel(6'h14, 8'h9A, 32'h3344559A);
        pressRel(6'h0F, 8'hFF, 32'hFFFFFFFF);
        pressRel(6'h22, 8'hEE, 32'h00000000);
        check("clear_value", value, 0);
        check("clear_acc_load1", dut.accState[1], 0);
        pressRel(6'h01, 8'h9A, 32'h0000009A);
        btn_load[3] = 1'b1;
        cyc(8);
        #2 rst = 1'b1;
        #1;
        check("async_rst_value", value, 0);
        check("async_rst_upd", value_upd, 0);
        check("async_rst_blank", blank_mask, 0);
        check("async_rst_acc", dut.accState, 0);
        cyc(2);
        rst = 1'b0;
        cyc(30);
        check("held_no_commit", value, 0);
        dips = 8'hC3;
        btn_load[3] = 1'b0;
        sbQ.push_back(32'hC3000000);
        cyc(30);
        pressRel(6'h02, 8'h12, 32'hC3001200);
`ifdef SSD_BLINK_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bm[i] = blank_mask;
        end
        ok = 1'b1;
        for (int i = 0; i < 32; i++)
            if (bm[i+8] !== (bm[i] ^ 4'b0010) || (bm[i] !== 4'b0000 && bm[i] !== 4'b0010)) ok = 1'b0;
        check("blink_toggle", ok, 1);
        pressRel(6'h20, 8'h00, 32'h00000000);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (blank_mask !== 4'b0000) ok = 1'b0;
        end
        check("blink_after_clear", ok, 1);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bm[i] = blank_mask;
        end
        ok = 1'b1;
        for (int i = 0; i < 40; i++)
            if (bm[i] !== 4'b0000) ok = 1'b0;
        check("blank_const_zero", ok, 1);
`endif
        cyc(5);
        check("sb_drained", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
